// File: rtl/regfile_sb.sv
// Scoreboarded GPR file with HI/LO registers and a post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    issue_we,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic                    hi_we,
    input  logic                    lo_we,
    input  logic [DATA_W-1:0]       hi_i,
    input  logic [DATA_W-1:0]       lo_i,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    ready
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                ready_q;
    logic [NREG-1:0]     pending_q;
    logic [NREG-1:0]     pending_d;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   mem_q [NREG];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                run;

    assign run   = (state_q == ST_RUN);
    assign ready = ready_q;

    // Clear before set, so a same-cycle issue to the written register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (we) begin
            pending_d[waddr] = 1'b0;
        end
        if (issue_we && (issue_addr != '0)) begin
            pending_d[issue_addr] = 1'b1;
        end
    end

    // The array has a single write port shared by the clear sweep and writeback.
    always_comb begin
        if (!run) begin
            mem_we    = !rst;
            mem_waddr = idx_q;
            mem_wdata = '0;
        end else begin
            mem_we    = !rst && we && (waddr != '0);
            mem_waddr = waddr;
            mem_wdata = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            pending_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_q <= idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pending_q <= pending_d;
                    if (hi_we) begin
                        hi_q <= hi_i;
                    end
                    if (lo_we) begin
                        lo_q <= lo_i;
                    end
                end
            endcase
        end
    end

    assign hi_o = (BYP_EN && run && hi_we) ? hi_i : hi_q;
    assign lo_o = (BYP_EN && run && lo_we) ? lo_i : lo_q;

    // Read priority: not-ready / zero register, then forwarding, then the array.
    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              byp;

            assign ra  = raddr[gi*ADDR_W +: ADDR_W];
            assign byp = BYP_EN && run && we && (waddr == ra);

            assign rdata[gi*DATA_W +: DATA_W] = (!run || (ra == '0)) ? '0
                                              : byp ? wdata
                                              : mem_q[ra];
            assign rd_busy[gi] = !run | ((ra != '0) & pending_q[ra] & ~byp);
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table, directed corner sequences
// and randomized traffic checked against a behavioural model.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int NRD    = 2;
    localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [NRD*ADDR_W-1:0]  raddr;
    logic [NRD*DATA_W-1:0]  rdata;
    logic [NRD-1:0]         rd_busy;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   issue_we;
    logic [ADDR_W-1:0]      issue_addr;
    logic                   hi_we;
    logic                   lo_we;
    logic [DATA_W-1:0]      hi_i;
    logic [DATA_W-1:0]      lo_i;
    logic [DATA_W-1:0]      hi_o;
    logic [DATA_W-1:0]      lo_o;
    logic                   ready;

    int tests = 0;
    int fails = 0;

    regfile_sb #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue_we(issue_we), .issue_addr(issue_addr),
        .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: architectural registers, pending set, HI/LO, sweep progress.
    logic [DATA_W-1:0] m_reg [NREG];
    bit                m_pend [NREG];
    logic [DATA_W-1:0] m_hi, m_lo;
    bit                m_ready;
    int                m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_hi    = '0;
            m_lo    = '0;
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREG) m_ready = 1'b1;
        end else begin
            if (we) begin
                if (waddr != 0) m_reg[waddr] = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (issue_we && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            if (hi_we) m_hi = hi_i;
            if (lo_we) m_lo = lo_i;
        end
        #1;
    endtask

    function automatic logic [DATA_W-1:0] e_rd(input logic [ADDR_W-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (BYP && we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic e_busy(input logic [ADDR_W-1:0] a);
        if (!m_ready) return 1'b1;
        if (a == 0) return 1'b0;
        if (BYP && we && waddr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check_all(input string tag);
        logic [ADDR_W-1:0] a;
        for (int p = 0; p < NRD; p++) begin
            a = raddr[p*ADDR_W +: ADDR_W];
            chk($sformatf("%s_rdata%0d_r%0d", tag, p, a), rdata[p*DATA_W +: DATA_W], e_rd(a));
            chk($sformatf("%s_busy%0d_r%0d", tag, p, a), rd_busy[p], e_busy(a));
        end
        chk({tag, "_hi"}, hi_o, (BYP && m_ready && hi_we) ? hi_i : m_hi);
        chk({tag, "_lo"}, lo_o, (BYP && m_ready && lo_we) ? lo_i : m_lo);
        chk({tag, "_ready"}, ready, m_ready);
    endtask

    task automatic idle();
        we = 1'b0; issue_we = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rst = 1'b0;
    endtask

    // Reset pulse followed by the clear sweep; counts edges until ready.
    task automatic sweep(input string tag);
        int n = 0;
        int bad = 0;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_reset_ready"}, ready, 0);
        chk({tag, "_reset_hi"}, hi_o, 0);
        chk({tag, "_reset_lo"}, lo_o, 0);
        chk({tag, "_reset_busy"}, rd_busy, 2'b11);
        while (ready !== 1'b1 && n < 40) begin
            raddr = 10'($urandom);
            we = 1'b1; waddr = 5'($urandom); wdata = $urandom; issue_we = 1'b1;
            issue_addr = 5'($urandom); hi_we = 1'b1; hi_i = $urandom;
            #1;
            if (rdata !== '0 || rd_busy !== 2'b11 || hi_o !== '0) bad++;
            tick();
            n++;
        end
        idle();
        chk({tag, "_outputs_while_clearing_bad"}, bad, 0);
        chk({tag, "_edges_to_ready"}, n, NREG);
        $display("[TB] %s: ready after %0d edges", tag, n);
        for (int r = 0; r < NREG; r++) begin
            raddr = {5'd0, 5'(r)};
            #1;
            chk($sformatf("%s_zero_r%0d", tag, r), {rd_busy[0], rdata[DATA_W-1:0]}, '0);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              iw;
        logic [ADDR_W-1:0] ia;
        logic              hw;
        logic [DATA_W-1:0] hv;
        logic              lw;
        logic [DATA_W-1:0] lv;
        logic [ADDR_W-1:0] ra0;
        logic [ADDR_W-1:0] ra1;
        logic [DATA_W-1:0] ed0;
        logic [DATA_W-1:0] ed1;
        logic [1:0]        eb;
        logic [DATA_W-1:0] ehi;
        logic [DATA_W-1:0] elo;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0};
        tbl[1] = '{1, 0, 32'h00001234, 0, 0, 0, 0, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0};
        tbl[2] = '{0, 0, 32'h0, 1, 3, 0, 0, 0, 0, 3, 5, 32'h0, 32'hDEADBEEF, 2'b01, 0, 0};
        tbl[3] = '{1, 3, 32'h11, 1, 3, 0, 0, 0, 0, 3, 3, 32'h11, 32'h11, 2'b11, 0, 0};
        tbl[4] = '{1, 3, 32'h22, 0, 0, 0, 0, 0, 0, 3, 0, 32'h22, 32'h0, 2'b00, 0, 0};
        tbl[5] = '{1, 9, 32'h1, 0, 0, 1, 32'h2, 1, 32'h3, 9, 3, 32'h1, 32'h22, 2'b00, 32'h2, 32'h3};
        tbl[6] = '{0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 9, 32'h0, 32'h1, 2'b00, 32'h2, 32'h3};

        idle();
        raddr = '0; waddr = '0; wdata = '0; issue_addr = '0; hi_i = '0; lo_i = '0;
        sweep("sweep0");

        for (int v = 0; v < 7; v++) begin
            we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
            issue_we = tbl[v].iw; issue_addr = tbl[v].ia;
            hi_we = tbl[v].hw; hi_i = tbl[v].hv; lo_we = tbl[v].lw; lo_i = tbl[v].lv;
            raddr = {tbl[v].ra1, tbl[v].ra0};
            tick();
            idle();
            #1;
            chk($sformatf("vec%0d_rdata0", v), rdata[31:0], tbl[v].ed0);
            chk($sformatf("vec%0d_rdata1", v), rdata[63:32], tbl[v].ed1);
            chk($sformatf("vec%0d_busy", v), rd_busy, tbl[v].eb);
            chk($sformatf("vec%0d_hi", v), hi_o, tbl[v].ehi);
            chk($sformatf("vec%0d_lo", v), lo_o, tbl[v].elo);
            $display("[TB] vec %0d: r%0d=%h r%0d=%h busy=%b", v, tbl[v].ra0, rdata[31:0],
                     tbl[v].ra1, rdata[63:32], rd_busy);
        end

        // Same-cycle writeback to a pending register that is being read.
        we = 1; waddr = 7; wdata = 32'h77; tick(); idle();
        issue_we = 1; issue_addr = 7; tick(); idle();
        we = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd7};
        hi_we = 1; hi_i = 32'hCAFE0001;
        #1;
        chk("bypass_rdata0", rdata[31:0], BYP ? 32'hA5A5A5A5 : 32'h77);
        chk("bypass_busy0", rd_busy[0], BYP ? 1'b0 : 1'b1);
        chk("bypass_hi", hi_o, BYP ? 32'hCAFE0001 : 32'h2);
        tick(); idle(); #1;
        chk("after_wb_rdata0", rdata[31:0], 32'hA5A5A5A5);
        chk("after_wb_busy0", rd_busy[0], 1'b0);
        chk("after_wb_hi", hi_o, 32'hCAFE0001);
        $display("[TB] bypass seq: r7=%h busy=%b hi=%h", rdata[31:0], rd_busy[0], hi_o);

        // Reset in the middle of traffic while r4 is pending.
        we = 1; waddr = 4; wdata = 32'h55; tick(); idle();
        issue_we = 1; issue_addr = 4; tick(); idle();
        raddr = {5'd0, 5'd4};
        #1;
        chk("midrst_pre_busy", rd_busy[0], 1'b1);
        chk("midrst_pre_data", rdata[31:0], 32'h55);
        sweep("sweep1");
        raddr = {5'd0, 5'd4};
        #1;
        chk("midrst_r4_data", rdata[31:0], 32'h0);
        chk("midrst_r4_busy", rd_busy[0], 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            issue_we = ($urandom_range(0, 2) == 0);
            issue_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            hi_we = ($urandom_range(0, 4) == 0);
            hi_i = $urandom;
            lo_we = ($urandom_range(0, 4) == 0);
            lo_i = $urandom;
            raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr[9:5] = ($urandom_range(0, 2) == 0) ? issue_addr : 5'($urandom);
            #1;
            check_all("rand");
            $display("[TB] rand %0d: rst=%b we=%b w=r%0d iw=%b i=r%0d rd=%h/%h busy=%b",
                     c, rst, we, waddr, issue_we, issue_addr, rdata[31:0], rdata[63:32], rd_busy);
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
